mult_pipe_array: RTL and testbench

- Fully pipelined, parametrised shift-add multiplier. Each pipeline stage retires BPS multiplier bits. The block accepts one operand pair per cycle and returns one product per cycle.
- Adds a valid/ready handshake with backpressure, a per-op signed/unsigned mode, tag pass-through, and a synchronous flush.
- Sits between an operand producer and a result consumer in the datapath. Replaces single-cell chains that have no flow control.

---
 rtl/mult_pipe_pkg.sv | 31 +++
 rtl/mult_pipe_array_stage.sv | 75 +++++++
 rtl/mult_pipe_array.sv | 105 ++++++++++
 tb/tb_mult_pipe_array.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared helpers for the pipelined shift-add multiplier: width derivation
// and the per-stage chunk multiply-add.
package mult_pipe_pkg;

  // Widest product the helpers handle; callers truncate to their own RW.
  localparam int MAX_W = 64;

  function automatic int rw_of(input int dw);
    return 2 * dw;
  endfunction

  function automatic int ns_of(input int dw, input int bps);
    return dw / bps;
  endfunction

  // acc + a_sh * chunk modulo 2^MAX_W; with neg_msb the chunk MSB weighs -2^(bps-1).
  function automatic logic [MAX_W-1:0] stage_step(
    input logic [MAX_W-1:0] acc,
    input logic [MAX_W-1:0] a_sh,
    input logic [MAX_W-1:0] chunk,
    input int               bps,
    input logic             neg_msb
  );
    logic [MAX_W-1:0] weight;
    weight = chunk;
    if (neg_msb && chunk[bps-1])
      weight = chunk - (MAX_W'(1) << bps);
    return acc + a_sh * weight;
  endfunction

endpackage

// File: rtl/mult_pipe_array_stage.sv
// One registered multiplier stage: applies its chunk step to the predecessor's
// state on load, holds when stalled, drops its op on flush.
module mult_pipe_stage
  import mult_pipe_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BPS   = 1,
  parameter int TAG_W = 4,
  parameter bit LAST  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              prev_vld,
  input  logic [2*DW-1:0]   prev_acc,
  input  logic [2*DW-1:0]   prev_a_sh,
  input  logic [DW-1:0]     prev_b_rem,
  input  logic              prev_sgn,
  input  logic [TAG_W-1:0]  prev_tag,
  output logic              vld,
  output logic [2*DW-1:0]   acc,
  output logic [2*DW-1:0]   a_sh,
  output logic [DW-1:0]     b_rem,
  output logic              sgn,
  output logic [TAG_W-1:0]  tag
);

  localparam int RW = 2 * DW;

  typedef struct packed {
    logic             vld;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    a_sh;
    logic [DW-1:0]    b_rem;
    logic             sgn;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t q;
  stage_t nxt;

  always_comb begin
    nxt.vld   = prev_vld;
    nxt.acc   = RW'(stage_step(MAX_W'(prev_acc), MAX_W'(prev_a_sh),
                               MAX_W'(prev_b_rem[BPS-1:0]), BPS,
                               LAST && prev_sgn));
    nxt.a_sh  = prev_a_sh << BPS;
    nxt.b_rem = prev_b_rem >> BPS;
    nxt.sgn   = prev_sgn;
    nxt.tag   = prev_tag;
  end

  // Payload only moves with a valid op, so a stalled or emptied stage keeps its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (flush)
      q.vld <= 1'b0;
    else if (load) begin
      if (prev_vld)
        q <= nxt;
      else
        q.vld <= 1'b0;
    end
  end

  assign vld   = q.vld;
  assign acc   = q.acc;
  assign a_sh  = q.a_sh;
  assign b_rem = q.b_rem;
  assign sgn   = q.sgn;
  assign tag   = q.tag;

endmodule

// File: rtl/mult_pipe_array.sv
// Fully pipelined shift-add multiplier with valid/ready flow control,
// per-op signed mode, tag pass-through and synchronous flush.
module mult_pipe_array
  import mult_pipe_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BPS   = 1,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DW-1:0]     in_a,
  input  logic [DW-1:0]     in_b,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [2*DW-1:0]   out_p,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int RW = rw_of(DW);
  localparam int NS = ns_of(DW, BPS);

  if (DW < 2 || (DW % BPS) != 0 || RW > MAX_W) begin : g_bad_cfg
    $error("mult_pipe_array: DW must be >= 2, a multiple of BPS, and at most 32");
  end

  logic [NS-1:0]    vld, rdy, sgn, p_vld, p_sgn;
  logic [RW-1:0]    acc [NS];
  logic [RW-1:0]    a_sh [NS];
  logic [DW-1:0]    b_rem [NS];
  logic [TAG_W-1:0] tag [NS];
  logic [RW-1:0]    p_acc [NS];
  logic [RW-1:0]    p_a_sh [NS];
  logic [DW-1:0]    p_b_rem [NS];
  logic [TAG_W-1:0] p_tag [NS];
  logic [RW-1:0]    a_ext;

  assign a_ext = in_signed ? {{DW{in_a[DW-1]}}, in_a} : {{DW{1'b0}}, in_a};

  // A stage may load when it is empty or its successor is moving this cycle.
  always_comb begin
    logic r;
    r   = out_rdy;
    rdy = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      r      = !vld[i] || r;
      rdy[i] = r;
    end
  end

  for (genvar i = 0; i < NS; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign p_vld[i]   = in_vld;
      assign p_acc[i]   = '0;
      assign p_a_sh[i]  = a_ext;
      assign p_b_rem[i] = in_b;
      assign p_sgn[i]   = in_signed;
      assign p_tag[i]   = in_tag;
    end else begin : g_body
      assign p_vld[i]   = vld[i-1];
      assign p_acc[i]   = acc[i-1];
      assign p_a_sh[i]  = a_sh[i-1];
      assign p_b_rem[i] = b_rem[i-1];
      assign p_sgn[i]   = sgn[i-1];
      assign p_tag[i]   = tag[i-1];
    end

    mult_pipe_stage #(
      .DW    (DW),
      .BPS   (BPS),
      .TAG_W (TAG_W),
      .LAST  (i == NS - 1)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (rdy[i]),
      .prev_vld   (p_vld[i]),
      .prev_acc   (p_acc[i]),
      .prev_a_sh  (p_a_sh[i]),
      .prev_b_rem (p_b_rem[i]),
      .prev_sgn   (p_sgn[i]),
      .prev_tag   (p_tag[i]),
      .vld        (vld[i]),
      .acc        (acc[i]),
      .a_sh       (a_sh[i]),
      .b_rem      (b_rem[i]),
      .sgn        (sgn[i]),
      .tag        (tag[i])
    );
  end

  assign in_rdy  = rdy[0] && !flush;
  assign out_vld = vld[NS-1];
  assign out_p   = acc[NS-1];
  assign out_tag = tag[NS-1];
  assign busy    = |vld;

endmodule

// File: tb/tb_mult_pipe_array.sv
// Directed self-checking bench for mult_pipe_array: BPS=1 main instance plus
// BPS=2 and BPS=4 instances sharing the same stimulus.
module tb_mult_pipe_array;

  logic        clk, rst_n, flush, in_vld, in_signed, out_rdy;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag;

  logic        in_rdy, out_vld, busy;
  logic [15:0] out_p;
  logic [3:0]  out_tag;
  logic        in_rdy_2, out_vld_2, busy_2;
  logic [15:0] out_p_2;
  logic [3:0]  out_tag_2;
  logic        in_rdy_4, out_vld_4, busy_4;
  logic [15:0] out_p_4;
  logic [3:0]  out_tag_4;

  int checks = 0;
  int errors = 0;

  mult_pipe_array #(.DW(8), .BPS(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_p(out_p), .out_tag(out_tag), .busy(busy)
  );

  mult_pipe_array #(.DW(8), .BPS(2), .TAG_W(4)) dut_2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_2),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_vld(out_vld_2), .out_rdy(out_rdy), .out_p(out_p_2), .out_tag(out_tag_2), .busy(busy_2)
  );

  mult_pipe_array #(.DW(8), .BPS(4), .TAG_W(4)) dut_4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_4),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_vld(out_vld_4), .out_rdy(out_rdy), .out_p(out_p_4), .out_tag(out_tag_4), .busy(busy_4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic s, input logic [3:0] t);
    in_vld    = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
    tick();
  endtask

  logic [7:0]  sa [4] = '{8'h80, 8'hFF, 8'h7F, 8'hFF};
  logic [7:0]  sb [4] = '{8'h80, 8'h7F, 8'h80, 8'hFF};
  logic        ss [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] sp [4] = '{16'h4000, 16'hFF81, 16'hC080, 16'hFE01};
  logic [7:0]  wa [2] = '{8'hFF, 8'hFF};
  logic        ws [2] = '{1'b0, 1'b1};
  logic [15:0] wp [2] = '{16'hFE01, 16'h0001};

  initial begin
    int n, idx, seen, n2, n4;
    logic [15:0] p2, p4;
    logic [3:0]  t2, t4;

    clk = 0; rst_n = 0; flush = 0; in_vld = 0; in_signed = 0;
    in_a = 0; in_b = 0; in_tag = 0; out_rdy = 1;

    // Reset state
    repeat (2) tick();
    checkOutput("rst_out_vld", 32'(out_vld), 0);
    checkOutput("rst_out_p", 32'(out_p), 0);
    checkOutput("rst_out_tag", 32'(out_tag), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    rst_n = 1;
    #1;
    checkOutput("rst_in_rdy", 32'(in_rdy), 1);
    tick();

    // Single unsigned op: latency counted in edges including the accept edge
    $display("[TB] single op latency");
    applyStimulus(8'd15, 8'd15, 1'b0, 4'd5);
    in_vld = 0;
    n = 1;
    while (!out_vld && n < 20) begin tick(); n++; end
    checkOutput("t1_latency", 32'(n), 8);
    checkOutput("t1_p", 32'(out_p), 32'h00E1);
    checkOutput("t1_tag", 32'(out_tag), 5);
    tick();
    checkOutput("t1_vld_drop", 32'(out_vld), 0);

    // Signed / unsigned corner products, back to back
    $display("[TB] signed corners");
    for (int k = 0; k < 4; k++) applyStimulus(sa[k], sb[k], ss[k], 4'(8 + k));
    in_vld = 0;
    n = 0;
    while (!out_vld && n < 20) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_vld", 32'(out_vld), 1);
      checkOutput("t2_p", 32'(out_p), 32'(sp[k]));
      checkOutput("t2_tag", 32'(out_tag), 32'(8 + k));
      tick();
    end

    // Eight back-to-back ops with tags 0..7
    $display("[TB] back to back");
    for (int k = 0; k < 8; k++) begin
      checkOutput("t3_in_rdy", 32'(in_rdy), 1);
      applyStimulus(8'(k + 1), 8'(2 * k + 3), 1'b0, 4'(k));
    end
    in_vld = 0;
    n = 0;
    while (!out_vld && n < 20) begin tick(); n++; end
    for (int k = 0; k < 8; k++) begin
      checkOutput("t3_vld", 32'(out_vld), 1);
      checkOutput("t3_p", 32'(out_p), 32'((k + 1) * (2 * k + 3)));
      checkOutput("t3_tag", 32'(out_tag), 32'(k));
      tick();
    end
    checkOutput("t3_drain", 32'(out_vld), 0);

    // Backpressure: fill with out_rdy low, stall, then release
    $display("[TB] backpressure");
    out_rdy = 0;
    for (int k = 0; k < 8; k++) applyStimulus(8'(20 + k), 8'(3 + k), 1'b0, 4'(k));
    in_a = 8'd28; in_b = 8'd11; in_tag = 4'd8; in_vld = 1;
    #1;
    checkOutput("t4_full_in_rdy", 32'(in_rdy), 0);
    checkOutput("t4_full_busy", 32'(busy), 1);
    checkOutput("t4_full_vld", 32'(out_vld), 1);
    checkOutput("t4_full_p", 32'(out_p), 60);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("t4_stall_in_rdy", 32'(in_rdy), 0);
      checkOutput("t4_stall_p", 32'(out_p), 60);
      checkOutput("t4_stall_tag", 32'(out_tag), 0);
    end
    out_rdy = 1;
    #1;
    checkOutput("t4_release_in_rdy", 32'(in_rdy), 1);
    checkOutput("t4_release_vld", 32'(out_vld), 1);
    tick();
    in_vld = 0;
    idx = 1;
    repeat (20) begin
      if (out_vld) begin
        if (idx < 9) begin
          checkOutput("t4_p", 32'(out_p), 32'((20 + idx) * (3 + idx)));
          checkOutput("t4_tag", 32'(out_tag), 32'(idx));
        end
        idx++;
      end
      tick();
    end
    checkOutput("t4_count", 32'(idx), 9);
    checkOutput("t4_busy", 32'(busy), 0);

    // Flush with three ops in flight and an input offered
    $display("[TB] flush");
    applyStimulus(8'd3, 8'd5, 1'b0, 4'd1);
    applyStimulus(8'd4, 8'd6, 1'b0, 4'd2);
    applyStimulus(8'd5, 8'd7, 1'b0, 4'd3);
    flush = 1; in_a = 8'd9; in_b = 8'd9; in_tag = 4'd15; in_vld = 1;
    #1;
    checkOutput("t5_flush_in_rdy", 32'(in_rdy), 0);
    checkOutput("t5_flush_busy_pre", 32'(busy), 1);
    tick();
    flush = 0; in_vld = 0;
    checkOutput("t5_flush_vld", 32'(out_vld), 0);
    checkOutput("t5_flush_busy", 32'(busy), 0);
    seen = 0;
    repeat (12) begin tick(); if (out_vld) seen++; end
    checkOutput("t5_flush_no_output", 32'(seen), 0);

    // Asynchronous reset with a product on the output
    applyStimulus(8'd7, 8'd6, 1'b0, 4'd3);
    applyStimulus(8'd5, 8'd5, 1'b0, 4'd4);
    in_vld = 0;
    n = 0;
    while (!out_vld && n < 20) begin tick(); n++; end
    checkOutput("t5_pre_rst_vld", 32'(out_vld), 1);
    #2;
    rst_n = 0;
    #1;
    checkOutput("t5_rst_vld", 32'(out_vld), 0);
    checkOutput("t5_rst_p", 32'(out_p), 0);
    checkOutput("t5_rst_tag", 32'(out_tag), 0);
    checkOutput("t5_rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1;
    tick();

    // Wider chunks: BPS=2 (4 stages) and BPS=4 (2 stages)
    $display("[TB] wide chunk builds");
    for (int c = 0; c < 2; c++) begin
      n2 = 0; n4 = 0; p2 = 0; p4 = 0; t2 = 0; t4 = 0;
      applyStimulus(wa[c], wa[c], ws[c], 4'(c + 1));
      in_vld = 0;
      n = 1;
      repeat (12) begin
        if (out_vld_2 && n2 == 0) begin n2 = n; p2 = out_p_2; t2 = out_tag_2; end
        if (out_vld_4 && n4 == 0) begin n4 = n; p4 = out_p_4; t4 = out_tag_4; end
        tick();
        n++;
      end
      checkOutput("t6_bps2_latency", 32'(n2), 4);
      checkOutput("t6_bps4_latency", 32'(n4), 2);
      checkOutput("t6_bps2_p", 32'(p2), 32'(wp[c]));
      checkOutput("t6_bps4_p", 32'(p4), 32'(wp[c]));
      checkOutput("t6_bps2_tag", 32'(t2), 32'(c + 1));
      checkOutput("t6_bps4_tag", 32'(t4), 32'(c + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
